// File: rtl/present_key_scheduler_pkg.sv
// Shared definitions for the PRESENT key-schedule engine and the cipher
// datapath that consumes its round keys.
//   KEY_SIZE_80 / KEY_SIZE_128 : the two legal cipher key widths
//   NUM_ROUNDS_DEF             : default number of schedule updates
//   RK_W                       : round-key width (always 64)
//   ks_state_t                 : key-schedule FSM states
//   present_sbox()             : 4-bit PRESENT S-box (C56B90AD3EF84712)
package present_pkg;

    localparam int KEY_SIZE_80    = 80;
    localparam int KEY_SIZE_128   = 128;
    localparam int NUM_ROUNDS_DEF = 31;
    localparam int RK_W           = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        DONE   = 2'd2
    } ks_state_t;

    function automatic logic [3:0] present_sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hC;
            4'h1: y = 4'h5;
            4'h2: y = 4'h6;
            4'h3: y = 4'hB;
            4'h4: y = 4'h9;
            4'h5: y = 4'h0;
            4'h6: y = 4'hA;
            4'h7: y = 4'hD;
            4'h8: y = 4'h3;
            4'h9: y = 4'hE;
            4'hA: y = 4'hF;
            4'hB: y = 4'h8;
            4'hC: y = 4'h4;
            4'hD: y = 4'h7;
            4'hE: y = 4'h1;
            default: y = 4'h2;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/present_key_scheduler_if.sv
// Handshake and round-key read bus between the key scheduler (slave) and
// its user (master).
//   start, key_in      : expansion request and cipher key
//   busy, done         : expansion status
//   rk_rd_idx          : round-key read index (0 = K1)
//   rk_rd_data         : selected round key
//   rk_stream(_valid)  : per-write key stream, only with PRESENT_KS_STREAM_EN
interface present_key_scheduler_if
    import present_pkg::*;
#(
    parameter int KEY_SIZE = KEY_SIZE_80
);
    logic                start;
    logic [KEY_SIZE-1:0] key_in;
    logic                busy;
    logic                done;
    logic [4:0]          rk_rd_idx;
    logic [RK_W-1:0]     rk_rd_data;

`ifdef PRESENT_KS_STREAM_EN
    logic [RK_W-1:0]     rk_stream;
    logic                rk_stream_valid;

    modport master (
        output start, key_in, rk_rd_idx,
        input  busy, done, rk_rd_data, rk_stream, rk_stream_valid
    );
    modport slave (
        input  start, key_in, rk_rd_idx,
        output busy, done, rk_rd_data, rk_stream, rk_stream_valid
    );
`else
    modport master (
        output start, key_in, rk_rd_idx,
        input  busy, done, rk_rd_data
    );
    modport slave (
        input  start, key_in, rk_rd_idx,
        output busy, done, rk_rd_data
    );
`endif

endinterface

// File: rtl/present_key_scheduler_ks_round.sv
// One PRESENT key-schedule update, purely combinational. Shared with the
// cipher's on-the-fly key variant.
//   key       : current key register contents
//   round_ctr : 5-bit round counter XORed into the key
//   key_next  : rotated, substituted, counter-mixed key
module present_ks_round
    import present_pkg::*;
#(
    parameter int KEY_SIZE = KEY_SIZE_80
) (
    input  logic [KEY_SIZE-1:0] key,
    input  logic [4:0]          round_ctr,
    output logic [KEY_SIZE-1:0] key_next
);

    logic [KEY_SIZE-1:0] rot;

    // Rotate left by 61 == rotate right by KEY_SIZE-61.
    assign rot = {key[KEY_SIZE-62:0], key[KEY_SIZE-1:KEY_SIZE-61]};

    generate
        if (KEY_SIZE == KEY_SIZE_128) begin : g_k128
            always_comb begin
                key_next          = rot;
                key_next[127:124] = present_sbox(rot[127:124]);
                key_next[123:120] = present_sbox(rot[123:120]);
                key_next[66:62]   = rot[66:62] ^ round_ctr;
            end
        end else if (KEY_SIZE == KEY_SIZE_80) begin : g_k80
            always_comb begin
                key_next        = rot;
                key_next[79:76] = present_sbox(rot[79:76]);
                key_next[19:15] = rot[19:15] ^ round_ctr;
            end
        end else begin : g_bad_key
            $error("present_ks_round: KEY_SIZE must be 80 or 128");
        end
    endgenerate

endmodule

// File: rtl/present_key_scheduler.sv
// PRESENT key-schedule engine: expands one 80- or 128-bit key into
// NUM_ROUNDS+1 64-bit round keys, one round per clock, into a buffer that
// the datapath reads at random.
// Optional feature macro: PRESENT_KS_STREAM_EN adds rk_stream /
// rk_stream_valid, a one-beat-per-write copy of every buffered round key.
//   clk  : system clock
//   rst  : synchronous active-high reset
//   bus  : present_key_scheduler_if.slave (start/key_in/busy/done/read port)
//
// state  | meaning
// IDLE   | no schedule held, waiting for start
// EXPAND | one key update per clock, writing rk_buf[ctr]
// DONE   | all round keys valid, reads enabled, start restarts
module present_key_scheduler
    import present_pkg::*;
#(
    parameter int KEY_SIZE   = KEY_SIZE_80,
    parameter int NUM_ROUNDS = NUM_ROUNDS_DEF,
    parameter int RK_W       = present_pkg::RK_W
) (
    input logic                     clk,
    input logic                     rst,
    present_key_scheduler_if.slave  bus
);

    localparam int         DEPTH = NUM_ROUNDS + 1;
    localparam int         IDX_W = $clog2(DEPTH);
    localparam logic [4:0] LAST  = 5'(NUM_ROUNDS);

    generate
        if (KEY_SIZE != KEY_SIZE_80 && KEY_SIZE != KEY_SIZE_128) begin : g_bad_key
            $error("present_key_scheduler: KEY_SIZE must be 80 or 128");
        end
        if (NUM_ROUNDS < 1 || NUM_ROUNDS > 31) begin : g_bad_rounds
            $error("present_key_scheduler: NUM_ROUNDS must be 1..31");
        end
        if (RK_W != 64) begin : g_bad_rkw
            $error("present_key_scheduler: RK_W must be 64");
        end
    endgenerate

    ks_state_t           state;
    logic [4:0]          ctr;
    logic [KEY_SIZE-1:0] key_reg;
    logic [KEY_SIZE-1:0] key_next;
    logic [RK_W-1:0]     rk_buf [DEPTH];
    logic                busy_q;
    logic                done_q;
    logic [RK_W-1:0]     rd_data;

`ifdef PRESENT_KS_STREAM_EN
    logic [RK_W-1:0]     stream_q;
    logic                stream_valid_q;
`endif

    present_ks_round #(
        .KEY_SIZE (KEY_SIZE)
    ) u_round (
        .key       (key_reg),
        .round_ctr (ctr),
        .key_next  (key_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ctr     <= '0;
            key_reg <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                rk_buf[i] <= '0;
            end
`ifdef PRESENT_KS_STREAM_EN
            stream_q       <= '0;
            stream_valid_q <= 1'b0;
`endif
        end else begin
`ifdef PRESENT_KS_STREAM_EN
            stream_valid_q <= 1'b0;
`endif
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        key_reg   <= bus.key_in;
                        rk_buf[0] <= bus.key_in[KEY_SIZE-1 -: RK_W];
                        ctr       <= 5'd1;
                        state     <= EXPAND;
                        busy_q    <= 1'b1;
                        done_q    <= 1'b0;
`ifdef PRESENT_KS_STREAM_EN
                        stream_q       <= bus.key_in[KEY_SIZE-1 -: RK_W];
                        stream_valid_q <= 1'b1;
`endif
                    end
                end
                EXPAND: begin
                    key_reg                <= key_next;
                    rk_buf[ctr[IDX_W-1:0]] <= key_next[KEY_SIZE-1 -: RK_W];
`ifdef PRESENT_KS_STREAM_EN
                    stream_q       <= key_next[KEY_SIZE-1 -: RK_W];
                    stream_valid_q <= 1'b1;
`endif
                    if (ctr == LAST) begin
                        // Counter parks on the last round rather than
                        // wrapping past 31.
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        ctr <= ctr + 5'd1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    // Reads are gated by done so the datapath never sees a partial schedule.
    always_comb begin
        rd_data = '0;
        if (done_q && (int'(bus.rk_rd_idx) <= NUM_ROUNDS)) begin
            rd_data = rk_buf[bus.rk_rd_idx[IDX_W-1:0]];
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.rk_rd_data = rd_data;

`ifdef PRESENT_KS_STREAM_EN
    assign bus.rk_stream       = stream_q;
    assign bus.rk_stream_valid = stream_valid_q;
`endif

endmodule

// File: tb/tb_present_key_scheduler.sv
// Self-checking bench for present_key_scheduler: an 80-bit/31-round, a
// 128-bit/31-round and an 80-bit/15-round instance, checked against a
// table of hand-computed round keys and an independent schedule model.
module tb_present_key_scheduler;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    present_key_scheduler_if #(.KEY_SIZE(80))  if80 ();
    present_key_scheduler_if #(.KEY_SIZE(128)) if128 ();
    present_key_scheduler_if #(.KEY_SIZE(80))  if15 ();

    present_key_scheduler #(.KEY_SIZE(80),  .NUM_ROUNDS(31)) u80  (.clk(clk), .rst(rst), .bus(if80.slave));
    present_key_scheduler #(.KEY_SIZE(128), .NUM_ROUNDS(31)) u128 (.clk(clk), .rst(rst), .bus(if128.slave));
    present_key_scheduler #(.KEY_SIZE(80),  .NUM_ROUNDS(15)) u15  (.clk(clk), .rst(rst), .bus(if15.slave));

    int tests = 0;
    int fails = 0;

    typedef struct {
        int          sel;
        logic [4:0]  idx;
        logic [63:0] exp;
        string       name;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] sb(input logic [3:0] x);
        logic [63:0] t;
        t = 64'hC56B90AD3EF84712;
        return t[63-4*int'(x) -: 4];
    endfunction

    function automatic logic [63:0] model_rk(input logic [127:0] key, input bit is128, input int idx);
        logic [79:0]  a;
        logic [127:0] b;
        logic [4:0]   rc;
        a = key[79:0];
        b = key;
        for (int r = 1; r <= idx; r++) begin
            rc = 5'(r);
            if (is128) begin
                b = (b << 61) | (b >> 67);
                b[127:124] = sb(b[127:124]);
                b[123:120] = sb(b[123:120]);
                b[66:62]   = b[66:62] ^ rc;
            end else begin
                a = (a << 61) | (a >> 19);
                a[79:76] = sb(a[79:76]);
                a[19:15] = a[19:15] ^ rc;
            end
        end
        return is128 ? b[127:64] : a[79:16];
    endfunction

    function automatic logic [63:0] rd(input int sel);
        case (sel)
            0:       return if80.rk_rd_data;
            1:       return if128.rk_rd_data;
            default: return if15.rk_rd_data;
        endcase
    endfunction

    function automatic logic done_of(input int sel);
        case (sel)
            0:       return if80.done;
            1:       return if128.done;
            default: return if15.done;
        endcase
    endfunction

    task automatic set_idx(input int sel, input logic [4:0] i);
        case (sel)
            0:       if80.rk_rd_idx = i;
            1:       if128.rk_rd_idx = i;
            default: if15.rk_rd_idx = i;
        endcase
    endtask

    task automatic check_all(input int sel, input logic [127:0] key, input bit is128,
                             input int n, input string tag);
        for (int i = 0; i <= n; i++) begin
            set_idx(sel, 5'(i));
            #1;
            chk($sformatf("%s_rk%0d", tag, i), rd(sel), model_rk(key, is128, i));
        end
    endtask

    task automatic wait_done(input int sel, input int max, output int n);
        n = 0;
        while (n < max) begin
            step();
            n++;
            if (done_of(sel)) return;
        end
        n = max + 1;
    endtask

    logic [127:0] key_a;
    logic [127:0] key_b;
    logic [127:0] key_c;
    int d80, d128, d15, n;

    initial begin
        vecs[0] = '{0, 5'd0,  64'h0000000000000000, "k80_rk0"};
        vecs[1] = '{0, 5'd1,  64'hC000000000000000, "k80_rk1"};
        vecs[2] = '{0, 5'd2,  64'h5000180000000001, "k80_rk2"};
        vecs[3] = '{0, 5'd31, 64'h6DAB31744F41D700, "k80_rk31"};
        vecs[4] = '{1, 5'd0,  64'h0000000000000000, "k128_rk0"};
        vecs[5] = '{1, 5'd1,  64'hCC00000000000000, "k128_rk1"};
        vecs[6] = '{2, 5'd1,  64'hC000000000000000, "nr15_rk1"};
        vecs[7] = '{2, 5'd2,  64'h5000180000000001, "nr15_rk2"};
        vecs[8] = '{2, 5'd16, 64'h0000000000000000, "nr15_idx16"};
        vecs[9] = '{2, 5'd31, 64'h0000000000000000, "nr15_idx31"};

        key_a = {48'h0, 80'h0123456789ABCDEF1357};
        key_b = {48'h0, 80'hFEDCBA98765432100F0F};
        key_c = {48'h0, 80'h13579BDF02468ACE5A5A};

        if80.start = 1'b0;  if80.key_in = '0;  if80.rk_rd_idx = '0;
        if128.start = 1'b0; if128.key_in = '0; if128.rk_rd_idx = '0;
        if15.start = 1'b0;  if15.key_in = '0;  if15.rk_rd_idx = '0;

        // Reset state
        step();
        step();
        rst = 1'b0;
        chk("reset_busy", 64'(if80.busy), 64'd0);
        chk("reset_done", 64'(if80.done), 64'd0);
        chk("reset_rd",   if80.rk_rd_data, 64'd0);
        chk("reset_done128", 64'(if128.done), 64'd0);

        // Zero key on all three instances; measure done latency
        if80.start = 1'b1; if128.start = 1'b1; if15.start = 1'b1;
        step();
        if80.start = 1'b0; if128.start = 1'b0; if15.start = 1'b0;
        if80.rk_rd_idx = 5'd31;
        d80 = 0; d128 = 0; d15 = 0;
        for (int c = 1; c <= 40; c++) begin
            step();
            if (c == 1) chk("busy_after_start", 64'(if80.busy), 64'd1);
            if (c == 5) chk("read_while_busy", if80.rk_rd_data, 64'd0);
            if (if80.done && d80 == 0)   d80 = c;
            if (if128.done && d128 == 0) d128 = c;
            if (if15.done && d15 == 0)   d15 = c;
        end
        chk("latency80",  64'(d80),  64'd31);
        chk("latency128", 64'(d128), 64'd31);
        chk("latency15",  64'(d15),  64'd15);
        chk("busy_in_done", 64'(if80.busy), 64'd0);

        for (int v = 0; v < 10; v++) begin
            set_idx(vecs[v].sel, vecs[v].idx);
            #1;
            chk(vecs[v].name, rd(vecs[v].sel), vecs[v].exp);
        end

        check_all(1, '0, 1'b1, 31, "k128_zero");
        check_all(2, '0, 1'b0, 15, "nr15_zero");

        // Reset in the middle of EXPAND
        rst = 1'b1; step(); rst = 1'b0;
        if80.key_in = key_a[79:0];
        if80.start = 1'b1;
        step();
        if80.start = 1'b0;
        for (int c = 0; c < 10; c++) step();
        rst = 1'b1; step(); rst = 1'b0;
        chk("midrst_busy", 64'(if80.busy), 64'd0);
        chk("midrst_done", 64'(if80.done), 64'd0);
        for (int i = 0; i <= 10; i += 5) begin
            set_idx(0, 5'(i));
            #1;
            chk($sformatf("midrst_rd%0d", i), if80.rk_rd_data, 64'd0);
        end
        step();
        if80.start = 1'b1;
        step();
        if80.start = 1'b0;
        wait_done(0, 40, n);
        chk("midrst_restart_lat", 64'(n), 64'd31);
        check_all(0, key_a, 1'b0, 31, "k80_a");

        // start held high for 40 edges, key changed mid-way
        rst = 1'b1; step(); rst = 1'b0;
        if80.key_in = key_b[79:0];
        if80.start = 1'b1;
        for (int e = 0; e < 40; e++) begin
            if (e == 10) if80.key_in = key_c[79:0];
            step();
            if (e == 30) chk("held_done_e30", 64'(if80.done), 64'd0);
            if (e == 31) begin
                chk("held_done_e31", 64'(if80.done), 64'd1);
                set_idx(0, 5'd31);
                #1;
                chk("held_first_rk31", if80.rk_rd_data, model_rk(key_b, 1'b0, 31));
                set_idx(0, 5'd0);
                #1;
                chk("held_first_rk0", if80.rk_rd_data, key_b[79:16]);
            end
            if (e == 32) begin
                chk("held_restart_done", 64'(if80.done), 64'd0);
                chk("held_restart_busy", 64'(if80.busy), 64'd1);
            end
        end
        if80.start = 1'b0;
        wait_done(0, 40, n);
        chk("held_restart_lat", 64'(n), 64'd24);
        check_all(0, key_c, 1'b0, 31, "k80_c");

`ifdef PRESENT_KS_STREAM_EN
        rst = 1'b1; step(); rst = 1'b0;
        chk("stream_reset_valid", 64'(if80.rk_stream_valid), 64'd0);
        chk("stream_reset_data",  if80.rk_stream, 64'd0);
        if80.key_in = '1;
        if80.start = 1'b1;
        step();
        if80.start = 1'b0;
        for (int c = 1; c <= 33; c++) begin
            if (c > 1) step();
            if (c <= 32) begin
                chk($sformatf("stream_valid%0d", c), 64'(if80.rk_stream_valid), 64'd1);
                chk($sformatf("stream_data%0d", c), if80.rk_stream,
                    model_rk({48'h0, {80{1'b1}}}, 1'b0, c - 1));
            end else begin
                chk("stream_valid_end", 64'(if80.rk_stream_valid), 64'd0);
            end
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
